// File: rtl/tile_sequencer_if.sv
// Host/core handshake bundle for tile_sequencer.
// The master modport is the sequencer side; the slave modport is the host/core side.
interface tile_sequencer_if #(
   parameter int addr_bw = 11
);
   logic               start;
   logic               ext_valid;
   logic               ext_ready;
   logic               l0_full;
   logic               l0_ready;
   logic               ofifo_valid;
   logic               wr_l0;
   logic               rd_l0;
   logic [1:0]         inst_w;
   logic               mode;
   logic               rd_ofifo;
   logic               psum_wr;
   logic               acc;
   logic [addr_bw-1:0] psum_addr;
   logic               relu;
   logic [3:0]         kij_idx;
   logic               iter_done;
   logic               compute_done;

   modport master (
      input  start, ext_valid, l0_full, l0_ready, ofifo_valid,
      output ext_ready, wr_l0, rd_l0, inst_w, mode, rd_ofifo, psum_wr, acc,
             psum_addr, relu, kij_idx, iter_done, compute_done
   );

   modport slave (
      output start, ext_valid, l0_full, l0_ready, ofifo_valid,
      input  ext_ready, wr_l0, rd_l0, inst_w, mode, rd_ofifo, psum_wr, acc,
             psum_addr, relu, kij_idx, iter_done, compute_done
   );
endinterface

// File: rtl/tile_sequencer.sv
// Multi-kij sequencer for the 8x8 systolic core: weight fill/push, activation fill/execute, psum drain.
// Optional macro TILE_SEQ_RELU_EN: assert relu on the psum writes of the final kernel position.
module tile_sequencer #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int num_inp = 64,
   parameter int kij_len = 9,
   parameter int addr_bw = 11
) (
   input  logic             clk,
   input  logic             reset,
   tile_sequencer_if.master bus
);
   // One counter serves every phase; the weight push runs row reads plus col-1 skew-flush cycles.
   localparam int PUSH_LAST = row + col - 2;
   localparam int CNT_MAX   = (num_inp > PUSH_LAST + 1) ? num_inp : PUSH_LAST + 1;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE, W_FILL, W_PUSH, X_FILL, EXEC, DRAIN, NEXT, DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       kij_q, kij_d;
   logic             last_kij;
   logic             xfer;
   logic             adv;

   assign last_kij = (kij_q == 4'(kij_len - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         kij_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kij_q   <= kij_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      kij_d            = kij_q;
      xfer             = 1'b0;
      adv              = 1'b0;
      bus.ext_ready    = 1'b0;
      bus.wr_l0        = 1'b0;
      bus.rd_l0        = 1'b0;
      bus.inst_w       = 2'b00;
      bus.mode         = 1'b0;
      bus.rd_ofifo     = 1'b0;
      bus.psum_wr      = 1'b0;
      bus.acc          = 1'b0;
      bus.psum_addr    = '0;
      bus.relu         = 1'b0;
      bus.kij_idx      = kij_q;
      bus.iter_done    = 1'b0;
      bus.compute_done = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = W_FILL;
               cnt_d   = '0;
               kij_d   = '0;
            end
         end
         W_FILL, X_FILL: begin
            bus.mode      = (state_q == X_FILL);
            bus.ext_ready = !bus.l0_full;
            xfer          = bus.ext_valid && !bus.l0_full;
            bus.wr_l0     = xfer;
            if (xfer) begin
               if ((state_q == W_FILL) && (cnt_q == CNT_W'(row - 1))) begin
                  cnt_d   = '0;
                  state_d = W_PUSH;
               end else if ((state_q == X_FILL) && (cnt_q == CNT_W'(num_inp - 1))) begin
                  cnt_d   = '0;
                  state_d = EXEC;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         W_PUSH: begin
            // Reads wait on l0_ready; the flush tail keeps kernel-load asserted with no read.
            if (cnt_q < CNT_W'(row)) begin
               if (bus.l0_ready) begin
                  bus.rd_l0  = 1'b1;
                  bus.inst_w = 2'b01;
                  adv        = 1'b1;
               end
            end else begin
               bus.inst_w = 2'b01;
               adv        = 1'b1;
            end
            if (adv) begin
               if (cnt_q == CNT_W'(PUSH_LAST)) begin
                  cnt_d   = '0;
                  state_d = X_FILL;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         EXEC: begin
            bus.mode = 1'b1;
            if (bus.l0_ready) begin
               bus.rd_l0  = 1'b1;
               bus.inst_w = 2'b10;
               if (cnt_q == CNT_W'(num_inp - 1)) begin
                  cnt_d   = '0;
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (bus.ofifo_valid) begin
               bus.rd_ofifo  = 1'b1;
               bus.psum_wr   = 1'b1;
               bus.psum_addr = addr_bw'(cnt_q);
               bus.acc       = (kij_q != 4'd0);
`ifdef TILE_SEQ_RELU_EN
               bus.relu      = last_kij;
`else
               bus.relu      = 1'b0;
`endif
               if (cnt_q == CNT_W'(num_inp - 1)) begin
                  cnt_d   = '0;
                  state_d = NEXT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         NEXT: begin
            bus.iter_done = 1'b1;
            if (last_kij) begin
               state_d = DONE;
            end else begin
               kij_d   = kij_q + 4'd1;
               state_d = W_FILL;
            end
         end
         DONE: begin
            bus.compute_done = 1'b1;
            if (bus.start) begin
               state_d = W_FILL;
               cnt_d   = '0;
               kij_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: expected psum writes are queued at run start and popped per write.
module tb_tile_sequencer;
   localparam int ROW     = 8;
   localparam int COL     = 8;
   localparam int NUM_INP = 64;
   localparam int KIJ_LEN = 9;
   localparam int ADDR_BW = 11;
   localparam int BUDGET  = 20000;

   typedef struct {
      int addr;
      bit acc;
      bit relu;
      int kij;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   tile_sequencer_if #(.addr_bw(ADDR_BW)) bus();

   tile_sequencer #(
      .row(ROW), .col(COL), .num_inp(NUM_INP), .kij_len(KIJ_LEN), .addr_bw(ADDR_BW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   exp_t sb[$];
   int nvec = 0;
   int nerr = 0;
   int cyc = 0;
   bit valid_toggle = 0, ready_toggle = 0, ofifo_toggle = 0;
   int stall_at = -1, stall_left = 0;
   int n_wfill, n_wpush, n_wread, n_xfill, n_exec, n_psum, n_pop, n_iter, n_both;
   bit prev_last_wr;

   task automatic clear_counts();
      n_wfill = 0; n_wpush = 0; n_wread = 0; n_xfill = 0; n_exec = 0;
      n_psum = 0; n_pop = 0; n_iter = 0; n_both = 0; prev_last_wr = 0;
   endtask

   task automatic push_run();
      exp_t e;
      for (int k = 0; k < KIJ_LEN; k++) begin
         for (int n = 0; n < NUM_INP; n++) begin
            e.addr = n;
            e.acc  = (k != 0);
`ifdef TILE_SEQ_RELU_EN
            e.relu = (k == KIJ_LEN - 1);
`else
            e.relu = 1'b0;
`endif
            e.kij  = k;
            sb.push_back(e);
         end
      end
   endtask

   // Drive this cycle's environment inputs, observe outputs just before the rising edge.
   task automatic tick();
      exp_t e;
      bit drove_full;
      bus.ext_valid   = valid_toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.l0_ready    = ready_toggle ? ((cyc % 3) != 1) : 1'b1;
      bus.ofifo_valid = ofifo_toggle ? ((cyc % 2) == 1) : 1'b1;
      drove_full      = (stall_left > 0);
      bus.l0_full     = drove_full;
      #3;
      if (drove_full) begin
         nvec++;
         if (bus.ext_ready !== 1'b0 || bus.wr_l0 !== 1'b0) begin
            nerr++;
            $display("FAIL stall_hold cyc=%0d got ext_ready=%b wr_l0=%b need 0/0", cyc, bus.ext_ready, bus.wr_l0);
         end
         stall_left--;
      end
      if (bus.wr_l0 === 1'b1 && bus.rd_l0 === 1'b1) n_both++;
      if (bus.wr_l0 === 1'b1) begin
         if (bus.mode === 1'b0) n_wfill++;
         else begin
            n_xfill++;
            if (n_xfill == stall_at) stall_left = 5;
         end
      end
      if (bus.inst_w === 2'b01) n_wpush++;
      if (bus.inst_w === 2'b01 && bus.rd_l0 === 1'b1) n_wread++;
      if (bus.inst_w === 2'b10 && bus.rd_l0 === 1'b1) n_exec++;
      if (bus.rd_ofifo === 1'b1) n_pop++;
      if (prev_last_wr) begin
         nvec++;
         if (bus.iter_done !== 1'b1) begin
            nerr++;
            $display("FAIL iter_done_latency cyc=%0d got %b need 1", cyc, bus.iter_done);
         end
         prev_last_wr = 0;
      end
      if (bus.iter_done === 1'b1) n_iter++;
      if (bus.psum_wr === 1'b1) begin
         nvec++;
         n_psum++;
         if (sb.size() == 0) begin
            nerr++;
            $display("FAIL psum_extra cyc=%0d got addr=%0d need no write", cyc, bus.psum_addr);
         end else begin
            e = sb.pop_front();
            if (bus.psum_addr !== ADDR_BW'(e.addr) || bus.acc !== e.acc || bus.relu !== e.relu ||
                bus.kij_idx !== 4'(e.kij) || bus.rd_ofifo !== 1'b1 || bus.ofifo_valid !== 1'b1) begin
               nerr++;
               $display("FAIL psum_write cyc=%0d got addr=%0d acc=%b relu=%b kij=%0d pop=%b vld=%b need addr=%0d acc=%b relu=%b kij=%0d pop=1 vld=1",
                        cyc, bus.psum_addr, bus.acc, bus.relu, bus.kij_idx, bus.rd_ofifo, bus.ofifo_valid,
                        e.addr, e.acc, e.relu, e.kij);
            end
            prev_last_wr = (e.addr == NUM_INP - 1);
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_idle_outputs(input string tag);
      nvec++;
      if ({bus.ext_ready, bus.wr_l0, bus.rd_l0, bus.inst_w, bus.mode, bus.rd_ofifo, bus.psum_wr,
           bus.acc, bus.relu, bus.iter_done, bus.compute_done} !== 12'd0) begin
         nerr++;
         $display("FAIL %s_ctrl got rdy=%b wr=%b rd=%b inst=%b mode=%b pop=%b pw=%b acc=%b relu=%b it=%b cd=%b need all 0",
                  tag, bus.ext_ready, bus.wr_l0, bus.rd_l0, bus.inst_w, bus.mode, bus.rd_ofifo,
                  bus.psum_wr, bus.acc, bus.relu, bus.iter_done, bus.compute_done);
      end
      nvec++;
      if (bus.psum_addr !== '0 || bus.kij_idx !== 4'd0) begin
         nerr++;
         $display("FAIL %s_idx got addr=%0d kij=%0d need 0/0", tag, bus.psum_addr, bus.kij_idx);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_idle_outputs("reset");
      tick();
      #1;
      check_idle_outputs("idle_hold");
   endtask

   task automatic run_full(input string tag, input bit poke_start);
      int budget;
      clear_counts();
      sb.delete();
      push_run();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      #1;
      nvec++;
      if (bus.ext_ready !== 1'b1 || bus.compute_done !== 1'b0 || bus.kij_idx !== 4'd0) begin
         nerr++;
         $display("FAIL %s_start got rdy=%b cd=%b kij=%0d need 1/0/0", tag, bus.ext_ready, bus.compute_done, bus.kij_idx);
      end
      budget = 0;
      while (bus.compute_done !== 1'b1 && budget < BUDGET) begin
         bus.start = (poke_start && budget >= 2 && budget < 4);
         tick();
         budget++;
      end
      bus.start = 1'b0;
      nvec++;
      if (bus.compute_done !== 1'b1) begin
         nerr++;
         $display("FAIL %s_timeout got compute_done=%b need 1 within %0d cycles", tag, bus.compute_done, BUDGET);
      end
      nvec++;
      if (n_wfill != ROW * KIJ_LEN || n_wread != ROW * KIJ_LEN || n_wpush != (ROW + COL - 1) * KIJ_LEN) begin
         nerr++;
         $display("FAIL %s_weights got fill=%0d rd=%0d push=%0d need %0d/%0d/%0d", tag, n_wfill, n_wread, n_wpush,
                  ROW * KIJ_LEN, ROW * KIJ_LEN, (ROW + COL - 1) * KIJ_LEN);
      end
      nvec++;
      if (n_xfill != NUM_INP * KIJ_LEN || n_exec != NUM_INP * KIJ_LEN) begin
         nerr++;
         $display("FAIL %s_acts got fill=%0d exec=%0d need %0d", tag, n_xfill, n_exec, NUM_INP * KIJ_LEN);
      end
      nvec++;
      if (n_psum != NUM_INP * KIJ_LEN || n_pop != n_psum || sb.size() != 0) begin
         nerr++;
         $display("FAIL %s_drain got wr=%0d pop=%0d left=%0d need %0d/%0d/0", tag, n_psum, n_pop, sb.size(),
                  NUM_INP * KIJ_LEN, NUM_INP * KIJ_LEN);
      end
      nvec++;
      if (n_iter != KIJ_LEN || n_both != 0 || bus.kij_idx !== 4'(KIJ_LEN - 1)) begin
         nerr++;
         $display("FAIL %s_iter got pulses=%0d overlap=%0d kij=%0d need %0d/0/%0d", tag, n_iter, n_both,
                  bus.kij_idx, KIJ_LEN, KIJ_LEN - 1);
      end
      tick();
      #1;
      nvec++;
      if (bus.compute_done !== 1'b1 || bus.ext_ready !== 1'b0) begin
         nerr++;
         $display("FAIL %s_done_hold got cd=%b rdy=%b need 1/0", tag, bus.compute_done, bus.ext_ready);
      end
   endtask

   task automatic test_basic();
      valid_toggle = 0; ready_toggle = 0; ofifo_toggle = 0; stall_at = -1;
      run_full("basic", 1'b0);
   endtask

   task automatic test_stalls();
      valid_toggle = 1; ready_toggle = 1; ofifo_toggle = 1; stall_at = 20;
      run_full("stall", 1'b1);
      stall_at = -1;
   endtask

   task automatic test_back_to_back();
      valid_toggle = 0; ready_toggle = 1; ofifo_toggle = 0;
      run_full("b2b", 1'b0);
   endtask

   task automatic test_reset_mid();
      int budget;
      valid_toggle = 0; ready_toggle = 0; ofifo_toggle = 0;
      clear_counts();
      sb.delete();
      push_run();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      budget = 0;
      #1;
      while (!(bus.kij_idx === 4'd3 && bus.inst_w === 2'b10) && budget < BUDGET) begin
         tick();
         #1;
         budget++;
      end
      nvec++;
      if (bus.kij_idx !== 4'd3 || bus.inst_w !== 2'b10) begin
         nerr++;
         $display("FAIL midrst_reach got kij=%0d inst=%b need 3/10", bus.kij_idx, bus.inst_w);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check_idle_outputs("midrst");
      sb.delete();
      run_full("after_rst", 1'b0);
   endtask

   initial begin
      bus.start = 1'b0; bus.ext_valid = 1'b0; bus.l0_full = 1'b0;
      bus.l0_ready = 1'b0; bus.ofifo_valid = 1'b0;
      clear_counts();
      @(negedge clk);
      test_reset();
      test_basic();
      test_stalls();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
